// File: rtl/hex_display_sched.sv
// Round-robin scheduler that shares one binary-to-seven-segment converter
// among four display channels, latching each result into that channel's HEX slot.
module hex_display_sched #(
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  wr_en,
  input  logic [27:0] wr_data,
  output logic [6:0]  drv_in,
  input  logic [7:0]  drv_out0,
  input  logic [7:0]  drv_out1,
  input  logic        drv_gt99,
  output logic [31:0] hex_ones,
  output logic [31:0] hex_tens,
  output logic [3:0]  ovf,
  output logic        busy,
  output logic        done,
  output logic [1:0]  done_ch
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [7:0] SEG_ZERO    = 8'b1100_0000;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [1:0]      grant_q, grant_d;
  logic [1:0]      last_grant_q, last_grant_d;
  logic [3:0]      pend_q, pend_d;
  logic [3:0][6:0] shadow_q, shadow_d;
  logic [6:0]      drv_in_q, drv_in_d;
  logic [3:0][7:0] hex_ones_q, hex_ones_d;
  logic [3:0][7:0] hex_tens_q, hex_tens_d;
  logic [3:0]      ovf_q, ovf_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [1:0]      done_ch_q, done_ch_d;

  logic            grant_found;
  logic [1:0]      grant_sel;
  logic [1:0]      cand;
  logic [3:0]      clear_mask;

  // Next-state logic: round-robin pick, settle countdown, capture, write path.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    drv_in_d     = drv_in_q;
    hex_ones_d   = hex_ones_q;
    hex_tens_d   = hex_tens_q;
    ovf_d        = ovf_q;
    done_d       = 1'b0;
    done_ch_d    = done_ch_q;
    clear_mask   = 4'b0000;
    grant_found  = 1'b0;
    grant_sel    = last_grant_q;
    cand         = last_grant_q;

    // Search begins one past the last grant so a busy channel cannot starve others.
    for (int k = 1; k <= 4; k++) begin
      cand = last_grant_q + 2'(k);
      if (!grant_found && pend_q[cand]) begin
        grant_found = 1'b1;
        grant_sel   = cand;
      end else begin
        grant_found = grant_found;
      end
    end

    case (state_q)
      IDLE: begin
        if (grant_found) begin
          state_d               = WAIT;
          cnt_d                 = 4'd0;
          grant_d               = grant_sel;
          last_grant_d          = grant_sel;
          drv_in_d              = shadow_q[grant_sel];
          clear_mask[grant_sel] = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == SETTLE_LAST) begin
          hex_ones_d[grant_q] = drv_out0;
          hex_tens_d[grant_q] = drv_out1;
          ovf_d[grant_q]      = drv_gt99;
          done_d              = 1'b1;
          done_ch_d           = grant_q;
          state_d             = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A write on the grant edge re-arms the channel: set beats clear.
    pend_d = (pend_q & ~clear_mask) | wr_en;
    for (int i = 0; i < 4; i++) begin
      shadow_d[i] = wr_en[i] ? wr_data[7*i +: 7] : shadow_q[i];
    end

    busy_d = (state_d == WAIT);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      grant_q      <= 2'd0;
      last_grant_q <= 2'd3;
      pend_q       <= 4'b0000;
      shadow_q     <= '{default: 7'd0};
      drv_in_q     <= 7'd0;
      hex_ones_q   <= '{default: SEG_ZERO};
      hex_tens_q   <= '{default: SEG_ZERO};
      ovf_q        <= 4'b0000;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      done_ch_q    <= 2'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      pend_q       <= pend_d;
      shadow_q     <= shadow_d;
      drv_in_q     <= drv_in_d;
      hex_ones_q   <= hex_ones_d;
      hex_tens_q   <= hex_tens_d;
      ovf_q        <= ovf_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      done_ch_q    <= done_ch_d;
    end
  end

  assign drv_in   = drv_in_q;
  assign hex_ones = hex_ones_q;
  assign hex_tens = hex_tens_q;
  assign ovf      = ovf_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign done_ch  = done_ch_q;

endmodule

// File: tb/tb_hex_display_sched.sv
// Self-checking bench for hex_display_sched: directed scenarios plus a randomized
// run compared against a transaction-level scheduler model.
module tb_hex_display_sched;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, reset4;
  logic [3:0]  wr_en, wr_en4;
  logic [27:0] wr_data, wr_data4;
  logic [6:0]  drv_in, drv_in4;
  logic [7:0]  drv_out0, drv_out1, drv_out0_4, drv_out1_4;
  logic        drv_gt99, drv_gt99_4;
  logic [31:0] hex_ones, hex_tens, hex_ones4, hex_tens4;
  logic [3:0]  ovf, ovf4;
  logic        busy, done, busy4, done4;
  logic [1:0]  done_ch, done_ch4;

  int checks = 0;
  int passed = 0;

  function automatic logic [7:0] seg(input int d);
    case (d)
      0: seg = 8'hC0;
      1: seg = 8'hF9;
      2: seg = 8'hA4;
      3: seg = 8'hB0;
      4: seg = 8'h99;
      5: seg = 8'h92;
      6: seg = 8'h82;
      7: seg = 8'hF8;
      8: seg = 8'h80;
      9: seg = 8'h90;
      default: seg = 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] conv_ones(input logic [6:0] v);
    conv_ones = (v > 7'd99) ? 8'hBF : seg(int'(v) % 10);
  endfunction

  function automatic logic [7:0] conv_tens(input logic [6:0] v);
    conv_tens = (v > 7'd99) ? 8'hBF : seg(int'(v) / 10);
  endfunction

  assign drv_out0   = conv_ones(drv_in);
  assign drv_out1   = conv_tens(drv_in);
  assign drv_gt99   = (drv_in > 7'd99);
  assign drv_out0_4 = conv_ones(drv_in4);
  assign drv_out1_4 = conv_tens(drv_in4);
  assign drv_gt99_4 = (drv_in4 > 7'd99);

  hex_display_sched #(.SETTLE(1)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .drv_in(drv_in), .drv_out0(drv_out0), .drv_out1(drv_out1), .drv_gt99(drv_gt99),
    .hex_ones(hex_ones), .hex_tens(hex_tens), .ovf(ovf),
    .busy(busy), .done(done), .done_ch(done_ch)
  );

  hex_display_sched #(.SETTLE(4)) dut4 (
    .clk(clk), .reset(reset4), .wr_en(wr_en4), .wr_data(wr_data4),
    .drv_in(drv_in4), .drv_out0(drv_out0_4), .drv_out1(drv_out1_4), .drv_gt99(drv_gt99_4),
    .hex_ones(hex_ones4), .hex_tens(hex_tens4), .ovf(ovf4),
    .busy(busy4), .done(done4), .done_ch(done_ch4)
  );

  task automatic cyc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset;
    reset = 1'b1; wr_en = 4'b0000; wr_data = 28'd0;
    cyc();
    reset = 1'b0;
  endtask

  task automatic do_reset4;
    reset4 = 1'b1; wr_en4 = 4'b0000; wr_data4 = 28'd0;
    cyc();
    reset4 = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (drv_in !== 7'd0) $display("FAIL reset_drv_in got %0d exp 0", drv_in); else passed++;
    checks++; if (hex_ones !== 32'hC0C0C0C0) $display("FAIL reset_hex_ones got %h exp c0c0c0c0", hex_ones); else passed++;
    checks++; if (hex_tens !== 32'hC0C0C0C0) $display("FAIL reset_hex_tens got %h exp c0c0c0c0", hex_tens); else passed++;
    checks++; if ({ovf, busy, done, done_ch} !== 8'd0) $display("FAIL reset_flags got %b exp 0", {ovf, busy, done, done_ch}); else passed++;
  endtask

  task automatic test_single;
    do_reset();
    wr_en = 4'b0001; wr_data = 28'd42;
    cyc();
    wr_en = 4'b0000;
    cyc();
    checks++; if (drv_in !== 7'd42 || busy !== 1'b1 || done !== 1'b0)
      $display("FAIL single_grant got drv_in=%0d busy=%b done=%b exp 42 1 0", drv_in, busy, done); else passed++;
    cyc();
    checks++; if (hex_tens !== 32'hC0C0C099) $display("FAIL single_tens got %h exp c0c0c099", hex_tens); else passed++;
    checks++; if (hex_ones !== 32'hC0C0C0A4) $display("FAIL single_ones got %h exp c0c0c0a4", hex_ones); else passed++;
    checks++; if (done !== 1'b1 || done_ch !== 2'd0 || ovf !== 4'd0 || busy !== 1'b0)
      $display("FAIL single_done got done=%b ch=%0d ovf=%b busy=%b exp 1 0 0000 0", done, done_ch, ovf, busy); else passed++;
  endtask

  task automatic test_four;
    logic [6:0] vals [4];
    vals[0] = 7'd7; vals[1] = 7'd35; vals[2] = 7'd68; vals[3] = 7'd99;
    do_reset();
    wr_en = 4'b1111; wr_data = {vals[3], vals[2], vals[1], vals[0]};
    cyc();
    wr_en = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      cyc();
      checks++; if (drv_in !== vals[c] || done !== 1'b0)
        $display("FAIL four_grant%0d got drv_in=%0d done=%b exp %0d 0", c, drv_in, done, vals[c]); else passed++;
      cyc();
      checks++; if (done !== 1'b1 || done_ch !== 2'(c))
        $display("FAIL four_done%0d got done=%b ch=%0d exp 1 %0d", c, done, done_ch, c); else passed++;
    end
    checks++; if (hex_tens !== 32'h9082B0C0) $display("FAIL four_tens got %h exp 9082b0c0", hex_tens); else passed++;
    checks++; if (hex_ones !== 32'h908092F8) $display("FAIL four_ones got %h exp 908092f8", hex_ones); else passed++;
  endtask

  task automatic test_overflow;
    do_reset();
    wr_en = 4'b0100; wr_data = 28'd120 << 14;
    cyc();
    wr_en = 4'b0000;
    cyc(); cyc();
    checks++; if (hex_tens[23:16] !== 8'hBF || hex_ones[23:16] !== 8'hBF || ovf !== 4'b0100)
      $display("FAIL ovf_set got %h/%h ovf=%b exp bf/bf 0100", hex_tens[23:16], hex_ones[23:16], ovf); else passed++;
    wr_en = 4'b0100; wr_data = 28'd55 << 14;
    cyc();
    wr_en = 4'b0000;
    cyc(); cyc();
    checks++; if (hex_tens[23:16] !== 8'h92 || hex_ones[23:16] !== 8'h92 || ovf !== 4'b0000)
      $display("FAIL ovf_clear got %h/%h ovf=%b exp 92/92 0000", hex_tens[23:16], hex_ones[23:16], ovf); else passed++;
  endtask

  task automatic test_fairness;
    logic [6:0] d0;
    int k;
    bit seen;
    d0 = 7'd0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      wr_en = 4'b0001; wr_data = {21'd0, d0}; d0 = d0 + 7'd1;
      cyc();
    end
    wr_en = 4'b0101; wr_data = {7'd0, 7'd33, 7'd0, d0}; d0 = d0 + 7'd1;
    cyc();
    seen = 1'b0; k = 0;
    for (int i = 1; i <= 10 && !seen; i++) begin
      wr_en = 4'b0001; wr_data = {21'd0, d0}; d0 = d0 + 7'd1;
      cyc();
      if (done === 1'b1 && done_ch === 2'd2) begin seen = 1'b1; k = i; end
    end
    wr_en = 4'b0000;
    checks++; if (!seen || k > 4)
      $display("FAIL fairness_latency got seen=%b edges=%0d exp capture within 4", seen, k); else passed++;
    checks++; if (hex_tens[23:16] !== 8'hB0 || hex_ones[23:16] !== 8'hB0)
      $display("FAIL fairness_slot2 got %h/%h exp b0/b0", hex_tens[23:16], hex_ones[23:16]); else passed++;
  endtask

  task automatic test_same_channel;
    do_reset();
    wr_en = 4'b0010; wr_data = 28'd10 << 7;
    cyc();
    wr_en = 4'b0000;
    cyc();
    checks++; if (drv_in !== 7'd10) $display("FAIL same_grant1 got %0d exp 10", drv_in); else passed++;
    wr_en = 4'b0010; wr_data = 28'd88 << 7;
    cyc();
    wr_en = 4'b0000;
    checks++; if (done !== 1'b1 || done_ch !== 2'd1 || hex_tens[15:8] !== 8'hF9 || hex_ones[15:8] !== 8'hC0)
      $display("FAIL same_first got done=%b ch=%0d %h/%h exp 1 1 f9/c0", done, done_ch, hex_tens[15:8], hex_ones[15:8]); else passed++;
    cyc();
    checks++; if (drv_in !== 7'd88 || busy !== 1'b1) $display("FAIL same_grant2 got %0d busy=%b exp 88 1", drv_in, busy); else passed++;
    cyc();
    checks++; if (done !== 1'b1 || done_ch !== 2'd1 || hex_tens[15:8] !== 8'h80 || hex_ones[15:8] !== 8'h80)
      $display("FAIL same_second got done=%b ch=%0d %h/%h exp 1 1 80/80", done, done_ch, hex_tens[15:8], hex_ones[15:8]); else passed++;
  endtask

  task automatic test_settle4;
    int k;
    do_reset4();
    wr_en4 = 4'b0001; wr_data4 = 28'd5;
    cyc();
    wr_en4 = 4'b0000;
    k = 0;
    for (int i = 1; i <= 12 && k == 0; i++) begin
      cyc();
      if (done4 === 1'b1) k = i;
    end
    checks++; if (k != 5) $display("FAIL settle4_latency got %0d edges exp 5", k); else passed++;
    checks++; if (hex_ones4[7:0] !== 8'h92 || hex_tens4[7:0] !== 8'hC0)
      $display("FAIL settle4_value got %h/%h exp c0/92", hex_tens4[7:0], hex_ones4[7:0]); else passed++;
  endtask

  task automatic test_reset_mid_wait;
    int bad;
    do_reset4();
    wr_en4 = 4'b0001; wr_data4 = 28'd77;
    cyc();
    wr_en4 = 4'b0000;
    cyc();
    checks++; if (drv_in4 !== 7'd77 || busy4 !== 1'b1)
      $display("FAIL midwait_grant got %0d busy=%b exp 77 1", drv_in4, busy4); else passed++;
    cyc();
    reset4 = 1'b1;
    cyc();
    reset4 = 1'b0;
    checks++; if (drv_in4 !== 7'd0 || busy4 !== 1'b0 || done4 !== 1'b0 || ovf4 !== 4'd0 ||
                  hex_ones4 !== 32'hC0C0C0C0 || hex_tens4 !== 32'hC0C0C0C0)
      $display("FAIL midwait_reset got drv_in=%0d busy=%b done=%b ovf=%b %h %h exp reset values",
               drv_in4, busy4, done4, ovf4, hex_tens4, hex_ones4); else passed++;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (done4 !== 1'b0 || busy4 !== 1'b0 || hex_ones4 !== 32'hC0C0C0C0) bad++;
    end
    checks++; if (bad != 0) $display("FAIL midwait_idle got %0d active cycles exp 0", bad); else passed++;
  endtask

  task automatic test_random;
    logic [6:0] m_shadow [4];
    logic [3:0] m_pend;
    logic [7:0] e_ones [4];
    logic [7:0] e_tens [4];
    logic [3:0] e_ovf;
    logic [1:0] m_last, m_ch, e_ch;
    logic [6:0] m_val;
    logic       e_done, m_active;
    logic [3:0] we;
    logic [27:0] wd;
    int m_left;
    int c;
    bit picked;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      m_shadow[i] = 7'd0; e_ones[i] = 8'hC0; e_tens[i] = 8'hC0;
    end
    m_pend = 4'd0; e_ovf = 4'd0; m_last = 2'd3; m_ch = 2'd0; e_ch = 2'd0;
    m_val = 7'd0; e_done = 1'b0; m_active = 1'b0; m_left = 0;
    for (int n = 0; n < 600; n++) begin
      we = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      wd = 28'($urandom);
      wr_en = we; wr_data = wd;
      cyc();
      e_done = 1'b0;
      if (m_active) begin
        m_left--;
        if (m_left == 0) begin
          e_ones[m_ch] = conv_ones(m_val);
          e_tens[m_ch] = conv_tens(m_val);
          e_ovf[m_ch]  = (m_val > 7'd99);
          e_done = 1'b1; e_ch = m_ch; m_active = 1'b0;
        end
      end else begin
        picked = 1'b0;
        for (int k = 1; k <= 4; k++) begin
          c = (int'(m_last) + k) % 4;
          if (!picked && m_pend[c]) begin
            picked = 1'b1; m_ch = 2'(c); m_val = m_shadow[c];
            m_pend[c] = 1'b0; m_last = 2'(c); m_active = 1'b1; m_left = 1;
          end
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (we[i]) begin
          m_shadow[i] = wd[7*i +: 7];
          m_pend[i] = 1'b1;
        end
      end
      checks++; if (drv_in !== m_val) $display("FAIL rand_drv_in cyc %0d got %0d exp %0d", n, drv_in, m_val); else passed++;
      checks++; if (hex_ones !== {e_ones[3], e_ones[2], e_ones[1], e_ones[0]})
        $display("FAIL rand_hex_ones cyc %0d got %h exp %h", n, hex_ones, {e_ones[3], e_ones[2], e_ones[1], e_ones[0]}); else passed++;
      checks++; if (hex_tens !== {e_tens[3], e_tens[2], e_tens[1], e_tens[0]})
        $display("FAIL rand_hex_tens cyc %0d got %h exp %h", n, hex_tens, {e_tens[3], e_tens[2], e_tens[1], e_tens[0]}); else passed++;
      checks++; if (ovf !== e_ovf || busy !== m_active || done !== e_done)
        $display("FAIL rand_flags cyc %0d got ovf=%b busy=%b done=%b exp %b %b %b", n, ovf, busy, done, e_ovf, m_active, e_done); else passed++;
      if (e_done) begin
        checks++; if (done_ch !== e_ch) $display("FAIL rand_done_ch cyc %0d got %0d exp %0d", n, done_ch, e_ch); else passed++;
      end
    end
    wr_en = 4'b0000;
  endtask

  initial begin
    reset = 1'b1; wr_en = 4'b0000; wr_data = 28'd0;
    reset4 = 1'b1; wr_en4 = 4'b0000; wr_data4 = 28'd0;
    @(negedge clk);
    test_reset();
    test_single();
    test_four();
    test_overflow();
    test_fairness();
    test_same_channel();
    test_settle4();
    test_reset_mid_wait();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
